// File: rtl/rst_sync_tick_gen.sv
// rst_sync_tick_gen: reset conditioner and phase-timing tick source.
// The reset output asserts asynchronously with rst_n and releases
// synchronously. Release passes through a SYNC_STAGES-deep chain and then
// a HOLD_CYCLES stretch. A prescaler then emits a one-cycle tick every DIV
// qualifying edges and counts the ticks it has issued.
module rst_sync_tick_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int DIV         = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  output logic             rst_n_sync,
  output logic             tick,
  output logic [CNT_W-1:0] tick_cnt
);

  // The hold counter must be able to represent HOLD_CYCLES.
  // The prescaler counts 0..DIV-1.
  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int DW = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam bit            NO_HOLD   = (HOLD_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_rise_s;
  state_e                 state_r;
  state_e                 state_next_s;
  logic [HW-1:0]          hold_cnt_r;
  logic [HW-1:0]          hold_next_s;
  logic                   rst_n_sync_r;
  logic                   qual_s;
  logic [DW-1:0]          div_cnt_r;
  logic                   tick_r;
  logic [CNT_W-1:0]       tick_cnt_r;

  // The chain output s goes high on this edge when the stage feeding it is
  // already high. Looking one stage ahead lets HOLD_CYCLES=0 enter RUN on
  // that same edge.
  assign s_rise_s = sync_r[SYNC_STAGES-2];

  // Reset synchronizer chain: shift ones in once rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Hold FSM next-state logic: ASSERT -> HOLD -> RUN, with RUN sticky.
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_cnt_r;
    case (state_r)
      ST_ASSERT: begin
        hold_next_s = '0;
        if (s_rise_s) begin
          if (NO_HOLD) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_HOLD;
          end
        end else begin
          state_next_s = ST_ASSERT;
        end
      end
      ST_HOLD: begin
        if ((hold_cnt_r + HW'(1)) == HOLD_LAST) begin
          state_next_s = ST_RUN;
          hold_next_s  = '0;
        end else begin
          state_next_s = ST_HOLD;
          hold_next_s  = hold_cnt_r + HW'(1);
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
        hold_next_s  = '0;
      end
      default: begin
        state_next_s = ST_ASSERT;
        hold_next_s  = '0;
      end
    endcase
  end

  // Hold FSM state and counter. The reset output is registered from the
  // next state so that it rises on the edge RUN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_ASSERT;
      hold_cnt_r   <= '0;
      rst_n_sync_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      hold_cnt_r   <= hold_next_s;
      rst_n_sync_r <= (state_next_s == ST_RUN);
    end
  end

  // An edge qualifies only once the conditioned reset is released and the
  // enable is high.
  assign qual_s = rst_n_sync_r & tick_en;

  // Prescaler and tick counter. Gating freezes the phase; it does not
  // clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r  <= '0;
      tick_r     <= 1'b0;
      tick_cnt_r <= '0;
    end else if (qual_s) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r  <= '0;
        tick_r     <= 1'b1;
        tick_cnt_r <= tick_cnt_r + CNT_W'(1);
      end else begin
        div_cnt_r  <= div_cnt_r + DW'(1);
        tick_r     <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign rst_n_sync = rst_n_sync_r;
  assign tick       = tick_r;
  assign tick_cnt   = tick_cnt_r;

endmodule

// File: tb/tb_rst_sync_tick_gen.sv
// Directed bench for rst_sync_tick_gen.
// u_dut uses the default parameters. u_cor uses the corner set
// DIV=1, HOLD_CYCLES=0, SYNC_STAGES=3. Both share clk and rst_n.
module tb_rst_sync_tick_gen;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic       tick_en_c;
  logic       rst_n_sync;
  logic       tick;
  logic [7:0] tick_cnt;
  logic       rst_n_sync_c;
  logic       tick_c;
  logic [7:0] tick_cnt_c;

  int total = 0;
  int bad   = 0;

  rst_sync_tick_gen #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .DIV(5), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .rst_n_sync(rst_n_sync), .tick(tick), .tick_cnt(tick_cnt)
  );

  rst_sync_tick_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(0), .DIV(1), .CNT_W(8)) u_cor (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en_c),
    .rst_n_sync(rst_n_sync_c), .tick(tick_c), .tick_cnt(tick_cnt_c)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk edges 1..6 after release: sync rises only after edge 6, and
  // tick/tick_cnt stay 0 throughout.
  task automatic check_release(input string tag);
    for (int e = 1; e <= 6; e++) begin
      step();
      total++;
      if (rst_n_sync !== (e >= 6)) begin
        $display("FAIL %s_sync edge=%0d got=%b exp=%b", tag, e, rst_n_sync, (e >= 6));
        bad++;
      end
      total++;
      if (tick !== 1'b0 || tick_cnt !== 8'd0) begin
        $display("FAIL %s_quiet edge=%0d got tick=%b cnt=%0d exp tick=0 cnt=0", tag, e, tick, tick_cnt);
        bad++;
      end
    end
  endtask

  // Power-up: rst_n falls before the first posedge and is released after
  // the second posedge.
  task automatic test_reset();
    rst_n = 1'b1; tick_en = 1'b1; tick_en_c = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (rst_n_sync !== 1'b0 || tick !== 1'b0 || tick_cnt !== 8'd0) begin
      $display("FAIL reset_values got sync=%b tick=%b cnt=%0d exp 0 0 0", rst_n_sync, tick, tick_cnt);
      bad++;
    end
    step(); step();
    rst_n = 1'b1;
    check_release("pwr");
  endtask

  // Ticks after qualifying edges 5, 10 and 15 with counts 1, 2 and 3.
  // The first qualifying edge is the one right after release completes.
  task automatic test_cadence();
    for (int q = 1; q <= 15; q++) begin
      step();
      total++;
      if (tick !== (q % 5 == 0)) begin
        $display("FAIL cadence_tick q=%0d got=%b exp=%b", q, tick, (q % 5 == 0));
        bad++;
      end
      total++;
      if (tick_cnt !== 8'(q / 5)) begin
        $display("FAIL cadence_cnt q=%0d got=%0d exp=%0d", q, tick_cnt, q / 5);
        bad++;
      end
    end
  endtask

  // Two qualifying edges bring div_cnt to 2, then three gated cycles
  // follow. The tick must arrive on the third re-enabled edge.
  task automatic test_gating();
    step(); step();
    tick_en = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step();
      total++;
      if (tick !== 1'b0 || tick_cnt !== 8'd3) begin
        $display("FAIL gate_frozen g=%0d got tick=%b cnt=%0d exp tick=0 cnt=3", g, tick, tick_cnt);
        bad++;
      end
    end
    tick_en = 1'b1;
    for (int q = 3; q <= 5; q++) begin
      step();
      total++;
      if (tick !== (q == 5) || tick_cnt !== ((q == 5) ? 8'd4 : 8'd3)) begin
        $display("FAIL gate_resume q=%0d got tick=%b cnt=%0d exp tick=%b", q, tick, tick_cnt, (q == 5));
        bad++;
      end
    end
  endtask

  // Keep ticking past 255 -> 0. The count is 4 here and the phase is 0.
  task automatic test_wrap();
    int         phase;
    logic [7:0] exp_cnt;
    logic       seen_wrap;
    phase     = 0;
    exp_cnt   = 8'd4;
    seen_wrap = 1'b0;
    for (int k = 0; k < 5 * 256; k++) begin
      step();
      phase++;
      if (phase == 5) begin
        phase = 0;
        if (exp_cnt == 8'd255) seen_wrap = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
      end
      total++;
      if (tick !== (phase == 0) || tick_cnt !== exp_cnt) begin
        $display("FAIL wrap k=%0d got tick=%b cnt=%0d exp tick=%b cnt=%0d", k, tick, tick_cnt, (phase == 0), exp_cnt);
        bad++;
      end
    end
    total++;
    if (seen_wrap !== 1'b1 || tick_cnt !== 8'd4) begin
      $display("FAIL wrap_done got wrapped=%b cnt=%0d exp wrapped=1 cnt=4", seen_wrap, tick_cnt);
      bad++;
    end
  endtask

  // A 3 ns rst_n glitch between edges clears everything at once, and the
  // full release latency then repeats.
  task automatic test_midrun_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rst_n_sync !== 1'b0 || tick !== 1'b0 || tick_cnt !== 8'd0) begin
      $display("FAIL glitch_clear got sync=%b tick=%b cnt=%0d exp 0 0 0", rst_n_sync, tick, tick_cnt);
      bad++;
    end
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (rst_n_sync !== 1'b0 || tick_cnt !== 8'd0) begin
      $display("FAIL glitch_held got sync=%b cnt=%0d exp 0 0", rst_n_sync, tick_cnt);
      bad++;
    end
    check_release("glitch");
  endtask

  // Corner instance after a fresh glitch reset: sync rises after edge 3,
  // and from edge 4 on tick stays high and tick_cnt advances by one each
  // cycle.
  task automatic test_corner();
    step();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      total++;
      if (rst_n_sync_c !== (e >= 3)) begin
        $display("FAIL corner_sync edge=%0d got=%b exp=%b", e, rst_n_sync_c, (e >= 3));
        bad++;
      end
      total++;
      if (tick_c !== (e >= 4) || tick_cnt_c !== ((e >= 4) ? 8'(e - 3) : 8'd0)) begin
        $display("FAIL corner_tick edge=%0d got tick=%b cnt=%0d exp tick=%b", e, tick_c, tick_cnt_c, (e >= 4));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_gating();
    test_wrap();
    test_midrun_reset();
    test_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
